// File: rtl/bp_pkg.sv
// Shared types and helpers for the local pattern history table port scheduler.
// An entry stores the full branch PC as a tag next to a 2-bit saturating counter.
package bp_pkg;

    localparam logic [1:0] CTR_INIT = 2'b01;

    typedef struct packed {
        logic [31:0] tag;
        logic [1:0]  ctr;
    } pht_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } upd_req_t;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_WR = 2'd2
    } sched_state_e;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Small FIFO of resolved-branch updates waiting for a free PHT port.
// The head entry is visible combinationally so the scheduler can address the table with it.
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter int Q = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  upd_req_t             i_data,
    input  logic                 i_pop,
    output upd_req_t             o_head,
    output logic [$clog2(Q):0]   o_count,
    output logic                 o_full,
    output logic                 o_empty
);
    localparam int AW = $clog2(Q);
    localparam int CW = AW + 1;

    upd_req_t          r_mem [Q];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CW'(Q));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pht_port_scheduler.sv
// Arbitrates the single PHT SRAM port between fetch lookups and queued execute-stage
// read-modify-write updates, after sweeping the table to its initial contents.
module pht_port_scheduler
    import bp_pkg::*;
#(
    parameter int N          = 128,
    parameter int Q          = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lookup_valid,
    input  logic [31:0]            lookup_pc,
    output logic                   lookup_ready,
    output logic                   resp_valid,
    output logic [31:0]            resp_pc,
    output logic                   resp_taken,
    input  logic                   upd_valid,
    input  logic [31:0]            upd_pc,
    input  logic                   upd_taken,
    output logic                   upd_ready,
    output logic                   init_done,
    output logic [$clog2(N)-1:0]   mem_addr,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [33:0]            mem_wdata,
    input  logic [33:0]            mem_rdata
);
    localparam int NB = $clog2(N);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = $clog2(Q) + 1;

    sched_state_e   r_state;
    logic           r_run;
    logic [NB-1:0]  r_init_idx;
    logic [SW-1:0]  r_starve;
    logic [31:0]    r_lk_pc;
    logic           r_resp_valid;
    logic           r_init_done;

    upd_req_t       w_head;
    upd_req_t       w_push_data;
    logic [CW-1:0]  w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_upd_win;
    logic           w_lk_acc;
    logic           w_push;
    logic           w_pop;
    logic [NB-1:0]  w_head_idx;
    pht_entry_t     w_rd_entry;
    pht_entry_t     w_wr_entry;

    assign w_rd_entry  = mem_rdata;
    assign w_head_idx  = w_head.pc[NB+1:2];
    assign w_push_data = '{pc: upd_pc, taken: upd_taken};

    // A queued update takes the port when nobody wants it, when the queue is full,
    // or once lookups have refused it for STARVE_MAX cycles.
    assign w_upd_win   = (r_state == ST_IDLE) && !w_empty &&
                         (!lookup_valid || w_full || (r_starve >= SW'(STARVE_MAX)));
    assign lookup_ready = (r_state == ST_IDLE) && !w_upd_win;
    assign w_lk_acc     = lookup_valid && lookup_ready;
    assign upd_ready    = (r_state != ST_INIT) && (w_count < CW'(Q));
    assign w_push       = upd_valid && upd_ready;
    assign w_pop        = (r_state == ST_UPD_WR);

    assign resp_valid = r_resp_valid;
    assign resp_pc    = r_lk_pc;
    assign resp_taken = r_resp_valid && (w_rd_entry.tag == r_lk_pc) && w_rd_entry.ctr[1];
    assign init_done  = r_init_done;

    // The counter is written back even when the stored tag belongs to another branch.
    assign w_wr_entry.tag = w_head.pc;
    assign w_wr_entry.ctr = w_head.taken ? sat_inc(w_rd_entry.ctr) : sat_dec(w_rd_entry.ctr);

    always_comb begin
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (r_state)
            ST_INIT: begin
                if (r_run) begin
                    mem_we    = 1'b1;
                    mem_addr  = r_init_idx;
                    mem_wdata = {32'h0, CTR_INIT};
                end
            end
            ST_IDLE: begin
                if (w_upd_win) begin
                    mem_re   = 1'b1;
                    mem_addr = w_head_idx;
                end else if (w_lk_acc) begin
                    mem_re   = 1'b1;
                    mem_addr = lookup_pc[NB+1:2];
                end
            end
            ST_UPD_WR: begin
                mem_we    = 1'b1;
                mem_addr  = w_head_idx;
                mem_wdata = w_wr_entry;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // r_run holds the sweep off for the first cycle so the memory port is quiet during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_INIT;
            r_run        <= 1'b0;
            r_init_idx   <= '0;
            r_starve     <= '0;
            r_lk_pc      <= '0;
            r_resp_valid <= 1'b0;
            r_init_done  <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_resp_valid <= w_lk_acc;
            if (w_lk_acc) r_lk_pc <= lookup_pc;
            case (r_state)
                ST_INIT: begin
                    if (r_run) begin
                        r_init_idx <= r_init_idx + 1'b1;
                        if (&r_init_idx) begin
                            r_state     <= ST_IDLE;
                            r_init_done <= 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (w_upd_win) begin
                        r_state  <= ST_UPD_WR;
                        r_starve <= '0;
                    end else if (w_lk_acc && !w_empty && (r_starve < SW'(STARVE_MAX))) begin
                        r_starve <= r_starve + 1'b1;
                    end
                end
                ST_UPD_WR: r_state <= ST_IDLE;
                default:   r_state <= ST_INIT;
            endcase
        end
    end

    bp_update_fifo #(.Q(Q)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_pht_port_scheduler.sv
// Bench for pht_port_scheduler: behavioural SRAM plus a table/queue reference model.
`timescale 1ns/1ps
module tb_pht_port_scheduler;
    localparam int N  = 128;
    localparam int Q  = 4;
    localparam int SM = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        lookup_ready;
    logic        resp_valid;
    logic [31:0] resp_pc;
    logic        resp_taken;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        upd_ready;
    logic        init_done;
    logic [6:0]  mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [33:0] mem_wdata;
    logic [33:0] mem_rdata = '0;

    logic [33:0] sram    [N];
    logic [31:0] ref_tag [N];
    logic [1:0]  ref_ctr [N];
    int n_cmp = 0;
    int n_err = 0;
    int n_pushed = 0;
    int n_upd_writes = 0;

    always #5 clk = ~clk;

    pht_port_scheduler #(.N(N), .Q(Q), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_ready(lookup_ready),
        .resp_valid(resp_valid), .resp_pc(resp_pc), .resp_taken(resp_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .init_done(init_done), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= sram[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we && init_done) n_upd_writes <= n_upd_writes + 1;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic ref_reset();
        for (int i = 0; i < N; i++) begin
            ref_tag[i] = '0;
            ref_ctr[i] = 2'b01;
        end
    endtask

    task automatic ref_apply(input logic [31:0] pc, input logic tk);
        int i;
        int c;
        i = int'(pc[8:2]);
        c = int'(ref_ctr[i]);
        c = tk ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
        ref_ctr[i] = 2'(c);
        ref_tag[i] = pc;
    endtask

    function automatic logic exp_pred(input logic [31:0] pc);
        int i;
        i = int'(pc[8:2]);
        return (ref_tag[i] == pc) && (ref_ctr[i] >= 2'd2);
    endfunction

    task automatic push_update(input logic [31:0] pc, input logic tk);
        int t;
        t = 0;
        upd_pc = pc; upd_taken = tk; upd_valid = 1'b1;
        while (!upd_ready && t < 200) begin tick(); t++; end
        n_cmp++;
        if (t >= 200) begin
            n_err++;
            $display("FAIL push_timeout pc=%h upd_ready stayed 0, required 1", pc);
        end
        tick();
        upd_valid = 1'b0;
        ref_apply(pc, tk);
        n_pushed++;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (n_upd_writes != n_pushed && t < 300) begin tick(); t++; end
        n_cmp++;
        if (t >= 300) begin
            n_err++;
            $display("FAIL drain_timeout writes=%0d required %0d", n_upd_writes, n_pushed);
        end
        tick();
    endtask

    task automatic do_lookup(input logic [31:0] pc, output logic vld, output logic [31:0] rpc,
                             output logic tk, output int waited);
        waited = 0;
        lookup_pc = pc; lookup_valid = 1'b1;
        #1;
        while (!lookup_ready && waited < 100) begin @(posedge clk); #2; waited++; end
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        vld = resp_valid; rpc = resp_pc; tk = resp_taken;
    endtask

    task automatic test_reset();
        int wr, rd, first;
        bit seq_ok, gate_ok;
        wr = 0; rd = 0; first = 0; seq_ok = 1; gate_ok = 1;
        rst_n = 1'b0; lookup_valid = 1'b0; upd_valid = 1'b0;
        ref_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({lookup_ready, resp_valid, resp_pc, resp_taken, upd_ready, init_done,
             mem_addr, mem_re, mem_we, mem_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got %h required 0", {lookup_ready, resp_valid, resp_pc,
                     resp_taken, upd_ready, init_done, mem_addr, mem_re, mem_we, mem_wdata});
        end
        rst_n = 1'b1;
        for (int k = 1; k <= N + 4; k++) begin
            tick();
            if (mem_we) begin
                if (mem_addr !== 7'(wr) || mem_wdata !== {32'h0, 2'b01}) seq_ok = 0;
                wr++;
            end
            if (mem_re) rd++;
            if (!init_done && (upd_ready || lookup_ready)) gate_ok = 0;
            if (init_done && first == 0) first = k;
        end
        n_cmp++; if (wr != N) begin n_err++; $display("FAIL sweep_count got %0d required %0d", wr, N); end
        n_cmp++; if (!seq_ok) begin n_err++; $display("FAIL sweep_sequence got out-of-order or wrong data, required addr 0..%0d data 1", N-1); end
        n_cmp++; if (rd != 0) begin n_err++; $display("FAIL sweep_reads got %0d required 0", rd); end
        n_cmp++; if (first != N + 1) begin n_err++; $display("FAIL init_done_cycle got %0d required %0d", first, N + 1); end
        n_cmp++; if (!gate_ok) begin n_err++; $display("FAIL init_ready_gate got ready=1 during sweep, required 0"); end
    endtask

    task automatic test_lookup_basic();
        logic v, tk; logic [31:0] p; int w;
        do_lookup(32'h40, v, p, tk, w);
        n_cmp++;
        if (v !== 1'b1 || p !== 32'h40 || w != 0) begin
            n_err++; $display("FAIL lookup_latency got v=%b pc=%h wait=%0d required v=1 pc=40 wait=0", v, p, w);
        end
        n_cmp++; if (tk !== 1'b0) begin n_err++; $display("FAIL lookup_cold got %b required 0", tk); end
        push_update(32'h40, 1'b1);
        push_update(32'h40, 1'b1);
        wait_drain();
        n_cmp++;
        if (sram[16] !== {ref_tag[16], ref_ctr[16]}) begin
            n_err++; $display("FAIL table_0x40 got %h required %h", sram[16], {ref_tag[16], ref_ctr[16]});
        end
        do_lookup(32'h40, v, p, tk, w);
        n_cmp++; if (tk !== exp_pred(32'h40)) begin n_err++; $display("FAIL lookup_trained got %b required %b", tk, exp_pred(32'h40)); end
    endtask

    task automatic test_saturation();
        logic v, tk; logic [31:0] p; int w;
        repeat (4) push_update(32'h80, 1'b1);
        wait_drain();
        n_cmp++; if (sram[32] !== {ref_tag[32], ref_ctr[32]}) begin n_err++; $display("FAIL sat_high got %h required %h", sram[32], {ref_tag[32], ref_ctr[32]}); end
        push_update(32'h80, 1'b0);
        wait_drain();
        n_cmp++; if (sram[32] !== {ref_tag[32], ref_ctr[32]}) begin n_err++; $display("FAIL sat_step_down got %h required %h", sram[32], {ref_tag[32], ref_ctr[32]}); end
        do_lookup(32'h80, v, p, tk, w);
        n_cmp++; if (tk !== exp_pred(32'h80)) begin n_err++; $display("FAIL sat_weak_taken got %b required %b", tk, exp_pred(32'h80)); end
        repeat (3) push_update(32'h80, 1'b0);
        wait_drain();
        n_cmp++; if (sram[32] !== {ref_tag[32], ref_ctr[32]}) begin n_err++; $display("FAIL sat_low got %h required %h", sram[32], {ref_tag[32], ref_ctr[32]}); end
        do_lookup(32'h80, v, p, tk, w);
        n_cmp++; if (tk !== exp_pred(32'h80)) begin n_err++; $display("FAIL sat_not_taken got %b required %b", tk, exp_pred(32'h80)); end
    endtask

    task automatic test_alias();
        logic v, tk; logic [31:0] p; int w;
        push_update(32'h40, 1'b1);
        wait_drain();
        do_lookup(32'h240, v, p, tk, w);
        n_cmp++; if (tk !== exp_pred(32'h240)) begin n_err++; $display("FAIL alias_miss got %b required %b", tk, exp_pred(32'h240)); end
        push_update(32'h240, 1'b1);
        push_update(32'h240, 1'b0);
        wait_drain();
        n_cmp++; if (sram[16] !== {ref_tag[16], ref_ctr[16]}) begin n_err++; $display("FAIL alias_overwrite got %h required %h", sram[16], {ref_tag[16], ref_ctr[16]}); end
        do_lookup(32'h240, v, p, tk, w);
        n_cmp++; if (tk !== exp_pred(32'h240)) begin n_err++; $display("FAIL alias_hit got %b required %b", tk, exp_pred(32'h240)); end
        do_lookup(32'h40, v, p, tk, w);
        n_cmp++; if (tk !== exp_pred(32'h40)) begin n_err++; $display("FAIL alias_old_tag got %b required %b", tk, exp_pred(32'h40)); end
    endtask

    task automatic test_contention();
        int refused, t;
        bit found;
        refused = 0; t = 0; found = 0;
        lookup_pc = 32'h400; lookup_valid = 1'b1;
        push_update(32'h104, 1'b1);
        while (!found && t < 50) begin
            #1;
            if (!lookup_ready && mem_re) found = 1;
            else begin
                if (lookup_ready) refused++;
                @(posedge clk); #1;
            end
            t++;
        end
        n_cmp++; if (!found || refused != SM) begin n_err++; $display("FAIL starve_preempt got refused=%0d found=%0d required refused=%0d found=1", refused, found, SM); end
        @(posedge clk); #2;
        n_cmp++;
        if (lookup_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 7'h41) begin
            n_err++; $display("FAIL starve_write got ready=%b we=%b addr=%h required ready=0 we=1 addr=41", lookup_ready, mem_we, mem_addr);
        end
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        wait_drain();
        n_cmp++; if (sram[65] !== {ref_tag[65], ref_ctr[65]}) begin n_err++; $display("FAIL starve_table got %h required %h", sram[65], {ref_tag[65], ref_ctr[65]}); end
    endtask

    task automatic test_fill();
        int t, bad;
        bit held;
        t = 0; bad = 0; held = 1;
        lookup_pc = 32'h404; lookup_valid = 1'b1;
        for (int i = 0; i < Q; i++) push_update(32'h200 + 32'(i * 4), 1'($urandom_range(0, 1)));
        #1;
        n_cmp++;
        if (lookup_ready !== 1'b0 || upd_ready !== 1'b0 || mem_re !== 1'b1) begin
            n_err++; $display("FAIL fill_block got lr=%b ur=%b re=%b required lr=0 ur=0 re=1", lookup_ready, upd_ready, mem_re);
        end
        while (!mem_we && t < 20) begin
            if (lookup_ready) held = 0;
            @(posedge clk); #2; t++;
        end
        if (lookup_ready) held = 0;
        @(posedge clk); #2;
        n_cmp++; if (!held || t >= 20) begin n_err++; $display("FAIL fill_hold got held=%0d cycles=%0d required held=1", held, t); end
        n_cmp++; if (lookup_ready !== 1'b1) begin n_err++; $display("FAIL fill_release got %b required 1", lookup_ready); end
        lookup_valid = 1'b0;
        @(posedge clk); #1;
        wait_drain();
        for (int i = 0; i < Q; i++) if (sram[i] !== {ref_tag[i], ref_ctr[i]}) bad++;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL fill_table got %0d wrong entries required 0", bad); end
    endtask

    task automatic test_random();
        logic exp_rv, exp_rtk, exp_lr, acc, pend_v, pend_tk, upd_win;
        logic [31:0] exp_rpc, pend_pc;
        logic [33:0] e;
        int q_cnt, q0, starve_m, bad, i;
        bit wr_phase;
        exp_rv = 0; exp_rtk = 0; exp_rpc = '0; pend_v = 0; pend_tk = 0; pend_pc = '0;
        q_cnt = 0; starve_m = 0; wr_phase = 0; bad = 0;
        for (int c = 0; c < 400; c++) begin
            n_cmp++;
            if (resp_valid !== exp_rv || (exp_rv && (resp_pc !== exp_rpc || resp_taken !== exp_rtk))) begin
                n_err++;
                $display("FAIL rand_resp cyc=%0d got v=%b pc=%h t=%b required v=%b pc=%h t=%b",
                         c, resp_valid, resp_pc, resp_taken, exp_rv, exp_rpc, exp_rtk);
            end
            lookup_valid = ($urandom_range(0, 99) < 60);
            lookup_pc = 32'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2));
            if (!pend_v && $urandom_range(0, 99) < 35) begin
                pend_v = 1'b1;
                pend_pc = 32'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2));
                pend_tk = 1'($urandom_range(0, 1));
            end
            upd_valid = pend_v; upd_pc = pend_pc; upd_taken = pend_tk;
            #1;
            q0 = q_cnt;
            upd_win = !wr_phase && (q_cnt > 0) && (!lookup_valid || q_cnt == Q || starve_m >= SM);
            exp_lr = !wr_phase && !upd_win;
            n_cmp++;
            if (lookup_ready !== exp_lr || upd_ready !== (q_cnt < Q)) begin
                n_err++;
                $display("FAIL rand_grant cyc=%0d got lr=%b ur=%b required lr=%b ur=%b",
                         c, lookup_ready, upd_ready, exp_lr, (q_cnt < Q));
            end
            acc = lookup_valid && exp_lr;
            exp_rv = acc;
            if (acc) begin
                i = int'(lookup_pc[8:2]);
                e = sram[i];
                exp_rpc = lookup_pc;
                exp_rtk = (e[33:2] == lookup_pc) && e[1];
                n_cmp++;
                if (mem_re !== 1'b1 || mem_addr !== 7'(i)) begin
                    n_err++; $display("FAIL rand_lookup_addr cyc=%0d got re=%b addr=%h required re=1 addr=%h", c, mem_re, mem_addr, 7'(i));
                end
            end
            if (wr_phase) begin wr_phase = 0; q_cnt--; end
            else if (upd_win) begin wr_phase = 1; starve_m = 0; end
            else if (acc && q_cnt > 0 && starve_m < SM) starve_m++;
            if (pend_v && q0 < Q) begin
                ref_apply(pend_pc, pend_tk);
                n_pushed++;
                q_cnt++;
                pend_v = 1'b0;
            end
            @(posedge clk); #1;
        end
        lookup_valid = 1'b0; upd_valid = 1'b0;
        if (pend_v) push_update(pend_pc, pend_tk);
        wait_drain();
        for (int k = 0; k < N; k++) if (sram[k] !== {ref_tag[k], ref_ctr[k]}) bad++;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rand_table got %0d wrong entries required 0", bad); end
    endtask

    task automatic test_reset_mid();
        int busy;
        busy = 0;
        lookup_valid = 1'b0;
        push_update(32'h3C0, 1'b1);
        tick();
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 7'h70) begin n_err++; $display("FAIL mid_setup got we=%b addr=%h required we=1 addr=70", mem_we, mem_addr); end
        #1; rst_n = 1'b0; #1;
        n_cmp++; if (mem_we !== 1'b0 || upd_ready !== 1'b0 || init_done !== 1'b0) begin n_err++; $display("FAIL mid_abort got we=%b ur=%b done=%b required 0 0 0", mem_we, upd_ready, init_done); end
        test_reset();
        n_pushed = n_upd_writes;
        for (int k = 0; k < 6; k++) begin
            if (mem_re || mem_we || !upd_ready) busy++;
            tick();
        end
        n_cmp++; if (busy != 0) begin n_err++; $display("FAIL mid_fifo_empty got %0d busy cycles required 0", busy); end
        n_cmp++; if (sram[112] !== {32'h0, 2'b01}) begin n_err++; $display("FAIL mid_entry got %h required %h", sram[112], {32'h0, 2'b01}); end
    endtask

    initial begin
        test_reset();
        test_lookup_basic();
        test_saturation();
        test_alias();
        test_contention();
        test_fill();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
